stump_sequencer: RTL and testbench

STUMP_SEQUENCER -- requirements
Module: stump_sequencer

---
 rtl/stump_sequencer_pkg.sv | 13 +
 rtl/stump_sequencer_if.sv | 21 ++
 rtl/stump_retire_counter.sv | 14 +
 rtl/stump_sequencer.sv | 61 ++++++
 tb/tb_stump_sequencer.sv | 124 ++++++++++++
 5 files changed

// File: rtl/stump_sequencer_pkg.sv
// stump_sequencer_pkg: shared Stump state encodings, opcode constants and decode helper
package stump_sequencer_pkg;
  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    MEMORY  = 2'b10,
    ILLEGAL = 2'b11
  } state_e;
  localparam logic [2:0] LDST = 3'b110;
  function automatic logic is_ldst(input logic [15:0] instr);
    return instr[15:13] == LDST;
  endfunction
endpackage

// File: rtl/stump_sequencer_if.sv
// stump_sequencer_if: memory handshake, condition-code inputs and sequencer status outputs
interface stump_sequencer_if #(parameter int COUNT_W = 16);
  logic               run;
  logic               mem_ready;
  logic [15:0]        mem_data_in;
  logic               cc_en;
  logic [3:0]         cc_in;
  logic [1:0]         state;
  logic [15:0]        ir;
  logic [3:0]         cc;
  logic [COUNT_W-1:0] instr_count;
  logic               illegal_state;
  modport master (
    output run, mem_ready, mem_data_in, cc_en, cc_in,
    input  state, ir, cc, instr_count, illegal_state
  );
  modport slave (
    input  run, mem_ready, mem_data_in, cc_en, cc_in,
    output state, ir, cc, instr_count, illegal_state
  );
endinterface

// File: rtl/stump_retire_counter.sv
// stump_retire_counter: W-bit wrap-around counter with enable
module stump_retire_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  end
  assign o_count = r_count;
endmodule

// File: rtl/stump_sequencer.sv
// stump_sequencer: FETCH/EXECUTE/MEMORY sequencer holding ir, cc and the retired-instruction count
module stump_sequencer
  import stump_sequencer_pkg::*;
#(parameter int COUNT_W = 16) (
  input logic              clk,
  input logic              rst,
  stump_sequencer_if.slave bus
);
  state_e               r_state, w_next;
  logic [15:0]          r_ir;
  logic [3:0]           r_cc;
  logic                 r_illegal;
  logic                 w_ir_load, w_cc_load, w_retire;
  logic [COUNT_W-1:0]   w_count;
  always_comb begin
    w_next    = FETCH;
    w_ir_load = 1'b0;
    w_cc_load = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      FETCH: begin
        w_ir_load = bus.run && bus.mem_ready;
        w_next    = w_ir_load ? EXECUTE : FETCH;
      end
      EXECUTE: begin
        w_cc_load = bus.cc_en;
        w_retire  = !is_ldst(r_ir);
        w_next    = w_retire ? FETCH : MEMORY;
      end
      MEMORY: begin
        w_retire = bus.mem_ready;
        w_next   = bus.mem_ready ? FETCH : MEMORY;
      end
      default: w_next = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_cc      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ir      <= w_ir_load ? bus.mem_data_in : r_ir;
      r_cc      <= w_cc_load ? bus.cc_in : r_cc;
      r_illegal <= r_illegal || (r_state == ILLEGAL);
    end
  end
  stump_retire_counter #(.W(COUNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_retire),
    .o_count (w_count)
  );
  assign bus.state         = r_state;
  assign bus.ir            = r_ir;
  assign bus.cc            = r_cc;
  assign bus.instr_count   = w_count;
  assign bus.illegal_state = r_illegal;
endmodule

// File: tb/tb_stump_sequencer.sv
// tb_stump_sequencer: table-driven vectors through a scoreboard queue plus hand-written corner sequences
module tb_stump_sequencer;
  import stump_sequencer_pkg::*;
  typedef struct {
    logic        run, rdy;
    logic [15:0] data;
    logic        cen;
    logic [3:0]  cin;
    logic [1:0]  st;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic [15:0] cnt;
    logic        ill;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t sb[$];
  vec_t tbl[16];
  stump_sequencer_if #(.COUNT_W(16)) bus ();
  stump_sequencer #(.COUNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic run, logic rdy, logic [15:0] data, logic cen, logic [3:0] cin,
                              logic [1:0] st, logic [15:0] ir, logic [3:0] cc, logic [15:0] cnt, logic ill);
    vec_t v;
    v.run = run; v.rdy = rdy; v.data = data; v.cen = cen; v.cin = cin;
    v.st = st; v.ir = ir; v.cc = cc; v.cnt = cnt; v.ill = ill;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.run = v.run; bus.mem_ready = v.rdy; bus.mem_data_in = v.data;
    bus.cc_en = v.cen; bus.cc_in = v.cin;
    sb.push_back(v);
  endtask
  task automatic sample(input string tag);
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_state"}, 32'(bus.state), 32'(e.st));
    chk({tag, "_ir"}, 32'(bus.ir), 32'(e.ir));
    chk({tag, "_cc"}, 32'(bus.cc), 32'(e.cc));
    chk({tag, "_cnt"}, 32'(bus.instr_count), 32'(e.cnt));
    chk({tag, "_ill"}, 32'(bus.illegal_state), 32'(e.ill));
  endtask
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    sample(tag);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_ir"}, 32'(bus.ir), 0);
    chk({tag, "_cc"}, 32'(bus.cc), 0);
    chk({tag, "_cnt"}, 32'(bus.instr_count), 0);
    chk({tag, "_ill"}, 32'(bus.illegal_state), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.run = 0; bus.mem_ready = 0; bus.mem_data_in = 0; bus.cc_en = 0; bus.cc_in = 0;
    tbl[0]  = mk(1, 1, 16'h0123, 0, 4'h0, 2'b01, 16'h0123, 4'h0, 16'd0, 0);
    tbl[1]  = mk(1, 1, 16'h0FFF, 1, 4'hA, 2'b00, 16'h0123, 4'hA, 16'd1, 0);
    tbl[2]  = mk(1, 1, 16'hC000, 1, 4'h5, 2'b01, 16'hC000, 4'hA, 16'd1, 0);
    tbl[3]  = mk(0, 0, 16'h1111, 0, 4'h5, 2'b10, 16'hC000, 4'hA, 16'd1, 0);
    tbl[4]  = mk(0, 0, 16'h1111, 1, 4'h5, 2'b10, 16'hC000, 4'hA, 16'd1, 0);
    tbl[5]  = mk(1, 0, 16'h1111, 1, 4'h5, 2'b10, 16'hC000, 4'hA, 16'd1, 0);
    tbl[6]  = mk(1, 0, 16'h1111, 0, 4'h5, 2'b10, 16'hC000, 4'hA, 16'd1, 0);
    tbl[7]  = mk(0, 1, 16'h1111, 1, 4'h5, 2'b00, 16'hC000, 4'hA, 16'd2, 0);
    for (int i = 8; i < 13; i++) tbl[i] = mk(0, 1, 16'hBEEF, 0, 4'h0, 2'b00, 16'hC000, 4'hA, 16'd2, 0);
    tbl[13] = mk(1, 0, 16'hBEEF, 0, 4'h0, 2'b00, 16'hC000, 4'hA, 16'd2, 0);
    tbl[14] = mk(1, 1, 16'h2345, 1, 4'h6, 2'b01, 16'h2345, 4'hA, 16'd2, 0);
    tbl[15] = mk(0, 0, 16'h0000, 1, 4'h6, 2'b00, 16'h2345, 4'h6, 16'd3, 0);
    #2;
    chk_reset("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step($sformatf("tbl%0d", i), tbl[i]);
    @(negedge clk);
    drive(mk(0, 1, 16'h0000, 0, 4'h0, 2'b00, 16'h2345, 4'h6, 16'hFFFF, 0));
    force dut.u_cnt.r_count = 16'hFFFF;
    #1;
    release dut.u_cnt.r_count;
    sample("preload");
    step("wrap_f", mk(1, 1, 16'h0123, 0, 4'h0, 2'b01, 16'h0123, 4'h6, 16'hFFFF, 0));
    step("wrap_e", mk(0, 0, 16'h0000, 0, 4'h0, 2'b00, 16'h0123, 4'h6, 16'h0000, 0));
    @(negedge clk);
    drive(mk(0, 1, 16'h0000, 1, 4'hF, 2'b00, 16'h0123, 4'h6, 16'h0000, 1));
    force dut.r_state = ILLEGAL;
    #1;
    release dut.r_state;
    sample("illegal");
    step("ill_hold", mk(0, 1, 16'h0000, 0, 4'h0, 2'b00, 16'h0123, 4'h6, 16'h0000, 1));
    step("ill_f", mk(1, 1, 16'hC000, 0, 4'h0, 2'b01, 16'hC000, 4'h6, 16'h0000, 1));
    step("ill_e", mk(1, 0, 16'h0000, 1, 4'h3, 2'b10, 16'hC000, 4'h3, 16'h0000, 1));
    #3;
    rst = 1'b1;
    #1;
    chk_reset("reset_mem");
    @(negedge clk);
    rst = 1'b0;
    step("post_f", mk(1, 1, 16'h0123, 0, 4'h0, 2'b01, 16'h0123, 4'h0, 16'd0, 0));
    step("post_e", mk(1, 1, 16'h0000, 0, 4'h0, 2'b00, 16'h0123, 4'h0, 16'd1, 0));
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
